// File: rtl/port_in_cond_pkg.sv
// ============================================================================
// Module  : port_pkg
// Brief   : Shared constants and arming-state encoding for the port input stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package port_pkg;

    localparam int PORT_WIDTH = 8;
    localparam int PORT_DEB_W = 4;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    typedef enum logic [1:0] {
        ARM0 = 2'd0,
        ARM1 = 2'd1,
        ARM2 = 2'd2,
        RUN  = 2'd3
    } arm_state_e;

endpackage

`default_nettype wire

// File: rtl/port_in_cond_if.sv
// ============================================================================
// Module  : port_in_cond_if
// Brief   : Pad, control and conditioned-result bundle of the port input stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface port_in_cond_if #(
    parameter int WIDTH = 8,
    parameter int DEB_W = 4
);
    logic [WIDTH-1:0] y_portX_i;
    logic [WIDTH-1:0] deb_en_i;
    logic [DEB_W-1:0] deb_len_i;
    logic [WIDTH-1:0] edge_sel_i;
    logic [WIDTH-1:0] int_en_i;
    logic [WIDTH-1:0] flag_clr_i;
    logic [WIDTH-1:0] port_val_o;
    logic [WIDTH-1:0] flag_o;
    logic             irq_o;

    modport master (
        output y_portX_i, deb_en_i, deb_len_i, edge_sel_i, int_en_i, flag_clr_i,
        input  port_val_o, flag_o, irq_o
    );

    modport slave (
        input  y_portX_i, deb_en_i, deb_len_i, edge_sel_i, int_en_i, flag_clr_i,
        output port_val_o, flag_o, irq_o
    );
endinterface

`default_nettype wire

// File: rtl/port_in_cond_bit.sv
// ============================================================================
// Module  : port_in_bit
// Brief   : One pin: 2-flop sync, optional debounce, edge detect, sticky flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module port_in_bit
    import port_pkg::*;
#(
    parameter int DEB_W = PORT_DEB_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             pad,
    input  wire logic             deb_en,
    input  wire logic [DEB_W-1:0] deb_len,
    input  wire logic             edge_sel,
    input  wire logic             flag_clr,
    input  wire logic             armed,
    output logic                  val,
    output logic                  flag
);

    logic             sync1;
    logic             sync2;
    logic             filt;
    logic             prev;
    logic [DEB_W-1:0] cnt;
    logic             filt_next;
    logic [DEB_W-1:0] cnt_next;
    logic [DEB_W-1:0] len_eff;
    logic [DEB_W:0]   cnt_inc;
    logic             edge_hit;

    always_comb begin
        len_eff   = (deb_len == '0) ? DEB_W'(1) : deb_len;
        cnt_inc   = {1'b0, cnt} + (DEB_W+1)'(1);
        filt_next = filt;
        cnt_next  = '0;
        if (!deb_en) begin
            filt_next = sync2;
        end else if (sync2 != filt) begin
            // >= rather than == so a shortened deb_len mid-count still terminates
            if (cnt_inc >= {1'b0, len_eff}) begin
                filt_next = sync2;
            end else begin
                cnt_next = cnt_inc[DEB_W-1:0];
            end
        end
        edge_hit = (edge_sel == EDGE_FALL) ? (~filt & prev) : (filt & ~prev);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            filt  <= 1'b0;
            prev  <= 1'b0;
            cnt   <= '0;
            flag  <= 1'b0;
        end else begin
            sync1 <= pad;
            sync2 <= sync1;
            filt  <= filt_next;
            cnt   <= cnt_next;
            // Until armed, prev follows the new level so RUN starts with no pending edge
            prev  <= armed ? filt : filt_next;
            if (armed && edge_hit) begin
                flag <= 1'b1;
            end else if (flag_clr) begin
                flag <= 1'b0;
            end
        end
    end

    assign val = filt;

endmodule

`default_nettype wire

// File: rtl/port_in_cond.sv
// ============================================================================
// Module  : port_in_cond
// Brief   : 8-pin port input conditioning with startup arming and IRQ reduce.
// Revision: 1.0
// ============================================================================
`default_nettype none

module port_in_cond
    import port_pkg::*;
#(
    parameter int WIDTH = PORT_WIDTH,
    parameter int DEB_W = PORT_DEB_W
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    port_in_cond_if.slave   bus
);

    arm_state_e       state;
    arm_state_e       state_next;
    logic             armed;
    logic [WIDTH-1:0] val_vec;
    logic [WIDTH-1:0] flag_vec;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ARM0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARM0:    state_next = ARM1;
            ARM1:    state_next = ARM2;
            ARM2:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign armed = (state == RUN);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            port_in_bit #(
                .DEB_W (DEB_W)
            ) u_bit (
                .clk      (clk_i),
                .rst      (rst_i),
                .pad      (bus.y_portX_i[i]),
                .deb_en   (bus.deb_en_i[i]),
                .deb_len  (bus.deb_len_i),
                .edge_sel (bus.edge_sel_i[i]),
                .flag_clr (bus.flag_clr_i[i]),
                .armed    (armed),
                .val      (val_vec[i]),
                .flag     (flag_vec[i])
            );
        end
    endgenerate

    assign bus.port_val_o = val_vec;
    assign bus.flag_o     = flag_vec;
    assign bus.irq_o      = |(flag_vec & bus.int_en_i);

endmodule

`default_nettype wire
